// File: rtl/game_rom_pkg.sv
// Shared types and iNES constants for the game ROM stream loader.
// Latency: n/a (declarations only).
// Backpressure: n/a. GAME_ROM_TRAINER_SKIP_EN adds the TRAINER state.
package game_rom_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
`ifdef GAME_ROM_TRAINER_SKIP_EN
      TRAINER,
`endif
      PRG,
      CHR,
      DONE,
      ERROR
   } loader_state_t;

   // "NES\x1A" with byte 0 in the least significant position
   localparam logic [31:0] INES_MAGIC     = 32'h1A53454E;
   localparam int          PRG_BANK_BYTES = 16384;
   localparam int          CHR_BANK_BYTES = 8192;
   localparam int          TRAINER_BYTES  = 512;
   localparam int          HEADER_BYTES   = 16;

endpackage

// File: rtl/game_rom_stream_loader_if.sv
// Byte-stream input and ROM write port bundle for the game ROM loader.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready handshake on the byte stream; ROM writes are unthrottled strobes.
interface game_rom_stream_loader_if #(
   parameter int ADDR_W = 16
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_data;
   logic              prg_rom_write;
   logic              chr_rom_write;

   // master: byte source / ROM sink side
   modport master (
      output in_data, in_valid,
      input  in_ready, rom_addr, rom_data, prg_rom_write, chr_rom_write
   );

   // slave: the loader itself
   modport slave (
      input  in_data, in_valid,
      output in_ready, rom_addr, rom_data, prg_rom_write, chr_rom_write
   );
endinterface

// File: rtl/ines_header_decode.sv
// Field extraction and legality check of a latched 16-byte iNES header.
// Latency: combinational.
// Backpressure: none. Without GAME_ROM_TRAINER_SKIP_EN a trainer flag makes the header illegal.
module ines_header_decode
   import game_rom_pkg::*;
#(
   parameter int PRG_ADDR_W = 15,
   parameter int CHR_ADDR_W = 13
) (
   input  logic [15:0][7:0] hdr,
   output logic             mirror,
   output logic             chr_ram,
   output logic [7:0]       mapper,
   output logic [7:0]       prg_banks,
   output logic [7:0]       chr_banks,
   output logic             legal
);

   logic magic_ok;
   logic prg_ok;
   logic chr_ok;
   logic trainer_ok;
   logic unused_hdr_bits;

   // Bytes 8..15 and the remaining flag bits carry nothing this loader uses.
   assign unused_hdr_bits = ^{hdr[15:8], hdr[7][3:0], hdr[6][3:1]};

   // Decode fields and check that the image fits the configured ROM capacity.
   always_comb begin
      mirror    = hdr[6][0];
      chr_ram   = (hdr[5] == 8'd0);
      mapper    = {hdr[7][7:4], hdr[6][7:4]};
      prg_banks = hdr[4];
      chr_banks = hdr[5];
      magic_ok  = ({hdr[3], hdr[2], hdr[1], hdr[0]} == INES_MAGIC);
      prg_ok    = (hdr[4] != 8'd0) && ({24'd0, hdr[4]} <= (32'd1 << (PRG_ADDR_W - 14)));
      chr_ok    = ({24'd0, hdr[5]} <= (32'd1 << (CHR_ADDR_W - 13)));
`ifdef GAME_ROM_TRAINER_SKIP_EN
      trainer_ok = 1'b1;
`else
      trainer_ok = !hdr[6][2];
`endif
      legal = magic_ok && prg_ok && chr_ok && trainer_ok;
   end

endmodule

// File: rtl/game_rom_stream_loader.sv
// Streams an iNES image into PRG/CHR ROM write ports, exporting header fields and status.
// Latency: write strobe 1 cycle after each PRG/CHR handshake; 1 byte/cycle sustained.
// Backpressure: in_ready low outside a load and in the header check cycle; in_valid gaps stall. Option: GAME_ROM_TRAINER_SKIP_EN.
module game_rom_stream_loader
   import game_rom_pkg::*;
#(
   parameter int PRG_ADDR_W = 15,
   parameter int CHR_ADDR_W = 13,
   parameter int ADDR_W     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   game_rom_stream_loader_if.slave   bus,
   output logic                      mirror,
   output logic                      chr_ram,
   output logic [7:0]                mapper,
   output logic [7:0]                prg_banks,
   output logic [7:0]                chr_banks,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   loader_state_t    state_q, state_d;
   logic [21:0]      cnt_q;
   logic [15:0][7:0] hdr_q;
   logic             hdr_valid;   // all 16 header bytes latched
   logic             active;
   logic             xfer;
   logic             phase_last;
   logic             start_ok;
   logic             dec_mirror, dec_chr_ram, dec_legal;
   logic [7:0]       dec_mapper, dec_prg_banks, dec_chr_banks;

   ines_header_decode #(
      .PRG_ADDR_W (PRG_ADDR_W),
      .CHR_ADDR_W (CHR_ADDR_W)
   ) u_decode (
      .hdr       (hdr_q),
      .mirror    (dec_mirror),
      .chr_ram   (dec_chr_ram),
      .mapper    (dec_mapper),
      .prg_banks (dec_prg_banks),
      .chr_banks (dec_chr_banks),
      .legal     (dec_legal)
   );

   // Handshake, status and end-of-phase detection derived from the current state.
   always_comb begin
      active = (state_q == HEADER) || (state_q == PRG) || (state_q == CHR);
`ifdef GAME_ROM_TRAINER_SKIP_EN
      active = active || (state_q == TRAINER);
`endif
      bus.in_ready = active && !((state_q == HEADER) && hdr_valid);
      busy         = active;
      done         = (state_q == DONE);
      error        = (state_q == ERROR);
      xfer         = bus.in_valid && bus.in_ready;
      start_ok     = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
      case (state_q)
         HEADER:  phase_last = (cnt_q == 22'(HEADER_BYTES - 1));
`ifdef GAME_ROM_TRAINER_SKIP_EN
         TRAINER: phase_last = (cnt_q == 22'(TRAINER_BYTES - 1));
`endif
         PRG:     phase_last = (cnt_q == ({dec_prg_banks, 14'd0} - 22'd1));
         CHR:     phase_last = (cnt_q == ({1'b0, dec_chr_banks, 13'd0} - 22'd1));
         default: phase_last = 1'b0;
      endcase
      // header fields read as zero until the check cycle
      mirror    = hdr_valid && dec_mirror;
      chr_ram   = hdr_valid && dec_chr_ram;
      mapper    = hdr_valid ? dec_mapper    : 8'd0;
      prg_banks = hdr_valid ? dec_prg_banks : 8'd0;
      chr_banks = hdr_valid ? dec_chr_banks : 8'd0;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; the header check occupies the cycle after byte 15.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: if (start) state_d = HEADER;
         HEADER: begin
            if (hdr_valid) begin
               if (!dec_legal)    state_d = ERROR;
`ifdef GAME_ROM_TRAINER_SKIP_EN
               else if (hdr_q[6][2]) state_d = TRAINER;
`endif
               else               state_d = PRG;
            end
         end
`ifdef GAME_ROM_TRAINER_SKIP_EN
         TRAINER: if (xfer && phase_last) state_d = PRG;
`endif
         PRG: if (xfer && phase_last) state_d = (dec_chr_banks == 8'd0) ? DONE : CHR;
         CHR: if (xfer && phase_last) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Byte counter, header capture and registered ROM write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q             <= '0;
         hdr_q             <= '0;
         hdr_valid         <= 1'b0;
         bus.prg_rom_write <= 1'b0;
         bus.chr_rom_write <= 1'b0;
         bus.rom_addr      <= '0;
         bus.rom_data      <= '0;
      end else begin
         bus.prg_rom_write <= 1'b0;
         bus.chr_rom_write <= 1'b0;
         if (start_ok) begin
            cnt_q     <= '0;
            hdr_q     <= '0;
            hdr_valid <= 1'b0;
         end else if (xfer) begin
            cnt_q <= phase_last ? '0 : cnt_q + 22'd1;
            if (state_q == HEADER) begin
               hdr_q[cnt_q[3:0]] <= bus.in_data;
               if (phase_last) hdr_valid <= 1'b1;
            end
            if ((state_q == PRG) || (state_q == CHR)) begin
               bus.prg_rom_write <= (state_q == PRG);
               bus.chr_rom_write <= (state_q == CHR);
               bus.rom_addr      <= cnt_q[ADDR_W-1:0];
               bus.rom_data      <= bus.in_data;
            end
         end
      end
   end

endmodule
